bus_arbiter: RTL and testbench

Two-master arbiter sharing the single slave-side bus between the 68000 CPU (master 0) and a second bus master such as DMA or a boot loader (master 1). It sits directly upstream of the address-decoding device multiplexer and presents one master port to it. It grants the bus per transaction with round-robin fairness. A per-transaction watchdog terminates cycles that no slave acknowledges and signals a bus error to the owning master.

---
 rtl/bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_bus_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: master 0 (CPU) and master 1 (DMA / boot loader)
// share one slave-side bus. Ownership is granted per transaction with
// round-robin tie-breaking. A watchdog turns an unacknowledged cycle into a
// bus error for the owning master.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 255  // legal range 1..65535
) (
  input  logic        clk,
  input  logic        reset,
  // master 0
  input  logic [15:0] m0_write,
  output logic [15:0] m0_read,
  input  logic [31:0] m0_addr,
  input  logic        m0_uds,
  input  logic        m0_lds,
  output logic        m0_ack,
  output logic        m0_berr,
  // master 1
  input  logic [15:0] m1_write,
  output logic [15:0] m1_read,
  input  logic [31:0] m1_addr,
  input  logic        m1_uds,
  input  logic        m1_lds,
  output logic        m1_ack,
  output logic        m1_berr,
  // slave bus
  output logic [15:0] s_write,
  input  logic [15:0] s_read,
  output logic [31:0] s_addr,
  output logic        s_uds,
  output logic        s_lds,
  input  logic        s_ack
);

  typedef enum logic [2:0] {
    IDLE,
    GRANT0,
    GRANT1,
    ERR0,
    ERR1
  } state_t;

  // Last wait count allowed before the watchdog fires.
  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

  state_t      state, state_next;
  logic        last_grant, last_grant_next;
  logic [15:0] wait_cnt, wait_cnt_next;
  logic        req0, req1;

  assign req0 = m0_uds | m0_lds;
  assign req1 = m1_uds | m1_lds;

  // State register, round-robin pointer and watchdog counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others; blocking here would create
    // order-dependent simulation and mismatch synthesis.
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;   // master 0 wins the first tie
      wait_cnt   <= '0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      wait_cnt   <= wait_cnt_next;
    end
  end

  // Next-state logic: arbitration in IDLE, completion/abort/watchdog in GRANT,
  // release of the error state once the master drops its strobes.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; a missing default would infer a latch.
    state_next      = state;
    last_grant_next = last_grant;
    wait_cnt_next   = wait_cnt;
    unique case (state)
      IDLE: begin
        if (req0 && (!req1 || last_grant)) begin
          state_next      = GRANT0;
          last_grant_next = 1'b0;
          wait_cnt_next   = '0;
        end else if (req1) begin
          state_next      = GRANT1;
          last_grant_next = 1'b1;
          wait_cnt_next   = '0;
        end
      end
      GRANT0: begin
        if (!req0) begin
          state_next = IDLE;
        end else if (!s_ack) begin
          if (wait_cnt == LAST_WAIT) state_next = ERR0;
          else                       wait_cnt_next = wait_cnt + 16'd1;
        end
      end
      GRANT1: begin
        if (!req1) begin
          state_next = IDLE;
        end else if (!s_ack) begin
          if (wait_cnt == LAST_WAIT) state_next = ERR1;
          else                       wait_cnt_next = wait_cnt + 16'd1;
        end
      end
      ERR0: if (!req0) state_next = IDLE;
      ERR1: if (!req1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output steering: the owner is wired straight through to the slave bus;
  // everything else, including s_ack arriving in IDLE or ERR, is masked to 0.
  always_comb begin
    s_write = '0;
    s_addr  = '0;
    s_uds   = 1'b0;
    s_lds   = 1'b0;
    m0_read = '0;
    m0_ack  = 1'b0;
    m0_berr = 1'b0;
    m1_read = '0;
    m1_ack  = 1'b0;
    m1_berr = 1'b0;
    unique case (state)
      GRANT0: begin
        s_write = m0_write;
        s_addr  = m0_addr;
        s_uds   = m0_uds;
        s_lds   = m0_lds;
        m0_read = s_read;
        m0_ack  = s_ack;
      end
      GRANT1: begin
        s_write = m1_write;
        s_addr  = m1_addr;
        s_uds   = m1_uds;
        s_lds   = m1_lds;
        m1_read = s_read;
        m1_ack  = s_ack;
      end
      ERR0:    m0_berr = 1'b1;
      ERR1:    m1_berr = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by
// randomized masters and slave, all compared every cycle against a
// transaction-level model of ownership, watchdog and round-robin rules.
module tb_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] m0_write, m0_read, m1_write, m1_read, s_write, s_read;
  logic [31:0] m0_addr, m1_addr, s_addr;
  logic        m0_uds, m0_lds, m0_ack, m0_berr;
  logic        m1_uds, m1_lds, m1_ack, m1_berr;
  logic        s_uds, s_lds, s_ack;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_write(m0_write), .m0_read(m0_read), .m0_addr(m0_addr),
    .m0_uds(m0_uds), .m0_lds(m0_lds), .m0_ack(m0_ack), .m0_berr(m0_berr),
    .m1_write(m1_write), .m1_read(m1_read), .m1_addr(m1_addr),
    .m1_uds(m1_uds), .m1_lds(m1_lds), .m1_ack(m1_ack), .m1_berr(m1_berr),
    .s_write(s_write), .s_read(s_read), .s_addr(s_addr),
    .s_uds(s_uds), .s_lds(s_lds), .s_ack(s_ack)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level reference: who owns the bus, whether the transaction
  // has failed, how many ack-less cycles it has seen, who won last.
  int  own = -1;
  bit  in_err;
  int  low_cycles;
  int  last_win = 1;
  bit  model_valid = 1'b0;
  int  cyc = 0;
  int  grant_log[$];
  int  grant_cyc[$];
  logic [85:0] exp_vec, obs_vec;
  bit  done_seen[2];

  // Behavioural masters for the protocol-driven phases.
  bit          active[2];
  logic        st_u[2], st_l[2];
  logic [31:0] st_a[2];
  logic [15:0] st_w[2];

  task automatic chk(input string tag, input logic [85:0] obs, input logic [85:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int i, input logic u, input logic l,
                       input logic [31:0] a, input logic [15:0] w);
    if (i == 0) begin
      m0_uds = u; m0_lds = l; m0_addr = a; m0_write = w;
    end else begin
      m1_uds = u; m1_lds = l; m1_addr = a; m1_write = w;
    end
  endtask

  // Let inputs settle, then compare every output against the model.
  task automatic settle();
    logic [15:0] e_sw;
    logic [31:0] e_sa;
    logic        e_su, e_sl;
    logic [15:0] e_rd[2];
    logic        e_ack[2], e_berr[2];
    #1;
    e_sw = '0; e_sa = '0; e_su = 1'b0; e_sl = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e_rd[i] = '0; e_ack[i] = 1'b0; e_berr[i] = 1'b0;
    end
    if (own == 0 && !in_err) begin
      e_sw = m0_write; e_sa = m0_addr; e_su = m0_uds; e_sl = m0_lds;
      e_rd[0] = s_read; e_ack[0] = s_ack;
    end
    if (own == 1 && !in_err) begin
      e_sw = m1_write; e_sa = m1_addr; e_su = m1_uds; e_sl = m1_lds;
      e_rd[1] = s_read; e_ack[1] = s_ack;
    end
    if (own >= 0 && in_err) e_berr[own] = 1'b1;
    exp_vec = {e_sw, e_sa, e_su, e_sl, e_rd[0], e_ack[0], e_berr[0],
               e_rd[1], e_ack[1], e_berr[1]};
    obs_vec = {s_write, s_addr, s_uds, s_lds, m0_read, m0_ack, m0_berr,
               m1_read, m1_ack, m1_berr};
    if (model_valid) chk($sformatf("outputs_cyc%0d", cyc), obs_vec, exp_vec);
    for (int i = 0; i < 2; i++) done_seen[i] = e_ack[i] | e_berr[i];
  endtask

  // Apply the arbitration rules to this cycle's inputs, then move to the
  // next cycle.
  task automatic advance();
    bit req[2];
    req[0] = m0_uds | m0_lds;
    req[1] = m1_uds | m1_lds;
    if (reset) begin
      own = -1; in_err = 1'b0; low_cycles = 0; last_win = 1; model_valid = 1'b1;
    end else if (own < 0) begin
      int w = -1;
      if (req[0] && req[1]) w = 1 - last_win;
      else if (req[0])      w = 0;
      else if (req[1])      w = 1;
      if (w >= 0) begin
        own = w; last_win = w; low_cycles = 0; in_err = 1'b0;
        grant_log.push_back(w);
        grant_cyc.push_back(cyc + 1);
      end
    end else if (!req[own]) begin
      own = -1; in_err = 1'b0;
    end else if (!in_err && !s_ack) begin
      low_cycles++;
      if (low_cycles == TO) in_err = 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  // A 68000-like master: holds its strobes until ack or berr, drops them the
  // next cycle. In random mode it also idles, aborts and lingers randomly.
  task automatic drive_master(input int i, input bit rnd);
    logic [1:0] s;
    if (active[i]) begin
      if (done_seen[i] && (!rnd || $urandom_range(0, 9) != 0)) active[i] = 1'b0;
      else if (rnd && $urandom_range(0, 29) == 0)             active[i] = 1'b0;
    end else if (!rnd || $urandom_range(0, 2) == 0) begin
      active[i] = 1'b1;
      s = 2'($urandom_range(1, 3));
      st_u[i] = s[1];
      st_l[i] = s[0];
      st_a[i] = rnd ? 32'($urandom) : 32'h0000_1000 + 32'(i);
      st_w[i] = 16'($urandom);
    end
    if (active[i]) set_m(i, st_u[i], st_l[i], st_a[i], st_w[i]);
    else           set_m(i, 1'b0, 1'b0, st_a[i], st_w[i]);
  endtask

  task automatic idle_all();
    set_m(0, 1'b0, 1'b0, '0, '0);
    set_m(1, 1'b0, 1'b0, '0, '0);
    active[0] = 1'b0;
    active[1] = 1'b0;
    s_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    s_ack = 1'b0;
    s_read = '0;
    for (int i = 0; i < 2; i++) begin
      st_u[i] = 1'b0; st_l[i] = 1'b0; st_a[i] = '0; st_w[i] = '0;
    end
    idle_all();
    @(negedge clk);
    step();
    step();
    reset = 1'b0;

    // Reset state: all outputs quiet.
    settle();
    chk("reset_outputs", obs_vec, 86'd0);
    advance();

    // Single read by master 0, slave acks two cycles after strobes appear.
    set_m(0, 1'b1, 1'b1, 32'h0010_0004, 16'h0000);
    step();                                            // cycle 0: IDLE
    settle();                                          // cycle 1
    chk("read_saddr_c1", 86'(s_addr), 86'(32'h0010_0004));
    chk("read_suds_c1", 86'({s_uds, s_lds}), 86'(2'b11));
    advance();
    step();                                            // cycle 2
    s_ack = 1'b1; s_read = 16'hBEEF;                   // cycle 3
    settle();
    chk("read_data", 86'(m0_read), 86'(16'hBEEF));
    chk("read_ack", 86'(m0_ack), 86'(1'b1));
    chk("read_m1_ack", 86'(m1_ack), 86'(1'b0));
    advance();
    set_m(0, 1'b0, 1'b0, 32'h0010_0004, 16'h0000);
    s_ack = 1'b0;
    step();
    step();

    // Both masters request continuously; slave acks in the first grant cycle.
    do_reset();
    grant_log.delete();
    grant_cyc.delete();
    for (int n = 0; n < 40 && grant_log.size() < 6; n++) begin
      drive_master(0, 1'b0);
      drive_master(1, 1'b0);
      s_ack = (own >= 0) && !in_err;
      step();
    end
    chk("rr_grant_count", 86'(grant_log.size() >= 6), 86'(1'b1));
    if (grant_log.size() >= 6) begin
      for (int k = 0; k < 6; k++)
        chk($sformatf("rr_order%0d", k), 86'(grant_log[k]), 86'(k % 2));
      for (int k = 1; k < 6; k++)
        chk($sformatf("rr_gap%0d", k), 86'(grant_cyc[k] - grant_cyc[k-1]), 86'(3));
    end
    idle_all();
    step();
    step();
    step();

    // Contention: master 1 requests while master 0 owns the bus.
    set_m(0, 1'b1, 1'b0, 32'h0000_A000, 16'h1234);
    step();                                            // c0: IDLE
    set_m(1, 1'b1, 1'b1, 32'h0000_B000, 16'h5678);
    for (int k = 1; k <= 2; k++) begin                 // c1, c2: GRANT0
      settle();
      chk($sformatf("cont_saddr_c%0d", k), 86'(s_addr), 86'(32'h0000_A000));
      chk($sformatf("cont_m1ack_c%0d", k), 86'(m1_ack), 86'(1'b0));
      advance();
    end
    set_m(0, 1'b0, 1'b0, 32'h0000_A000, 16'h1234);     // c3: m0 drops
    step();
    settle();                                          // c4: IDLE
    chk("cont_idle_strobe", 86'({s_uds, s_lds}), 86'(2'b00));
    advance();
    s_ack = 1'b1;                                      // c5: GRANT1
    settle();
    chk("cont_g1_saddr", 86'(s_addr), 86'(32'h0000_B000));
    chk("cont_g1_ack", 86'(m1_ack), 86'(1'b1));
    advance();
    set_m(1, 1'b0, 1'b0, 32'h0000_B000, 16'h5678);
    s_ack = 1'b0;
    step();
    step();

    // Timeout: master 1 alone, slave never acks.
    do_reset();
    set_m(1, 1'b1, 1'b1, 32'h0000_C000, 16'h0F0F);
    step();                                            // c0
    for (int k = 1; k <= 4; k++) begin                 // c1..c4: GRANT1
      settle();
      chk($sformatf("to_strobe_c%0d", k), 86'({s_uds, s_lds}), 86'(2'b11));
      chk($sformatf("to_berr_c%0d", k), 86'(m1_berr), 86'(1'b0));
      advance();
    end
    for (int k = 5; k <= 6; k++) begin                 // c5, c6: ERR1
      s_ack = (k == 6);                                // late ack is ignored
      settle();
      chk($sformatf("to_berr_c%0d", k), 86'(m1_berr), 86'(1'b1));
      chk($sformatf("to_strobe_c%0d", k), 86'({s_uds, s_lds}), 86'(2'b00));
      chk($sformatf("to_ack_c%0d", k), 86'(m1_ack), 86'(1'b0));
      advance();
    end
    s_ack = 1'b0;
    set_m(1, 1'b0, 1'b0, 32'h0000_C000, 16'h0F0F);     // c7: m1 drops
    settle();
    chk("to_berr_drop", 86'(m1_berr), 86'(1'b1));
    advance();
    settle();                                          // c8: IDLE
    chk("to_berr_idle", 86'(m1_berr), 86'(1'b0));
    advance();

    // Ack on the last allowed grant cycle.
    set_m(0, 1'b1, 1'b1, 32'h0000_D000, 16'h0000);
    step();                                            // c0
    step(); step(); step();                            // c1..c3
    s_ack = 1'b1; s_read = 16'h600D;                   // c4
    settle();
    chk("last_ack", 86'(m0_ack), 86'(1'b1));
    chk("last_berr", 86'(m0_berr), 86'(1'b0));
    advance();
    s_ack = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0000_D000, 16'h0000);     // c5
    settle();
    chk("last_berr_after", 86'(m0_berr), 86'(1'b0));
    advance();
    step();

    // Reset in the middle of a grant.
    set_m(0, 1'b1, 1'b1, 32'h0000_E000, 16'hAAAA);
    step();                                            // c0: IDLE
    step();                                            // c1: GRANT0
    reset = 1'b1;
    step();                                            // c2: reset sampled
    reset = 1'b0;
    set_m(1, 1'b1, 1'b1, 32'h0000_F000, 16'h5555);
    settle();                                          // c3: IDLE
    chk("rst_mid_outputs", obs_vec, 86'd0);
    advance();
    settle();                                          // c4: master 0 first
    chk("rst_mid_first", 86'(s_addr), 86'(32'h0000_E000));
    advance();
    idle_all();
    step();
    step();
    step();

    // Randomized masters, slave and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      drive_master(0, 1'b1);
      drive_master(1, 1'b1);
      s_ack  = ($urandom_range(0, 99) < 30);
      s_read = 16'($urandom);
      reset  = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    idle_all();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
